// File: rtl/fifo_types.sv
// rtl/fifo_types.sv - shared widths and serializer state encoding for the FIFO datapath
package fifo_types;

  localparam int width_p       = 32;
  localparam int chunk_width_p = 8;

  typedef enum logic {IDLE, SEND} ser_state_e;

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - drains FIFO words (valid/yumi) and emits LSB-first chunks (valid/ready/last)
module word_serializer
  import fifo_types::*;
#(
  parameter int word_width_p  = fifo_types::width_p,
  parameter int chunk_width_p = fifo_types::chunk_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     valid_i,
  input  logic [word_width_p-1:0]  data_i,
  output logic                     yumi_o,
  output logic                     valid_o,
  output logic [chunk_width_p-1:0] data_o,
  output logic                     last_o,
  input  logic                     ready_i
);

  localparam int chunks_p     = word_width_p / chunk_width_p;
  localparam int cnt_width_lp = (chunks_p > 2) ? $clog2(chunks_p) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(chunks_p - 1);

  ser_state_e               state_r, state_n;
  logic [word_width_p-1:0]  shift_r, shift_n;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_n;

  assign valid_o = (state_r == SEND);
  assign data_o  = shift_r[chunk_width_p-1:0];
  assign last_o  = valid_o & (cnt_r == last_cnt_lp);

  // Gated by reset so the producer never sees a consume while we are held in reset.
  assign yumi_o = reset_n_i & valid_i &
                  ((state_r == IDLE) | ((state_r == SEND) & last_o & ready_i));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      shift_r <= shift_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    cnt_n   = cnt_r;
    if (yumi_o) begin
      shift_n = data_i;
      cnt_n   = '0;
      state_n = SEND;
    end else if ((state_r == SEND) && ready_i) begin
      if (last_o) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        shift_n = shift_r >> chunk_width_p;
        cnt_n   = cnt_r + 1'b1;
      end
    end
  end

endmodule
